// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// operation codes, the sequencer state type and small decode helpers.
package cpu_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALU_W    = 5;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_BRX  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11010;

    // ALU codes share the encoding of the matching register-register opcode.
    localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'b00100;
    localparam logic [ALU_W-1:0] ALU_AND = 5'b00101;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'b00110;
    localparam logic [ALU_W-1:0] ALU_SHR = 5'b00111;
    localparam logic [ALU_W-1:0] ALU_SHL = 5'b01000;
    localparam logic [ALU_W-1:0] ALU_MUL = 5'b01100;
    localparam logic [ALU_W-1:0] ALU_DIV = 5'b01101;

    typedef enum logic [3:0] {
        RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT_S
    } state_t;

    // Final step of each opcode; nop and unknown opcodes end after fetch.
    function automatic state_t last_step(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:        return T5;
            OP_LD, OP_ST:                             return T7;
            OP_MUL, OP_DIV, OP_BRX:                   return T6;
            OP_JAL:                                   return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:   return T3;
            default:                                  return T2;
        endcase
    endfunction

    // ALU operation used in the compute step of each arithmetic opcode.
    function automatic logic [ALU_W-1:0] alu_for(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, opcode-specific execute steps
// in T3-T7, strobes decoded from state and the opcode field of IR_data.
//
// state   | meaning
// RESET_S | held by clear; all strobes low, Run low
// T0..T2  | instruction fetch (PC -> MAR, memory -> MDR -> IR)
// T3..T7  | execute steps; the opcode's last step returns to T0
// HALT_S  | halted after halt or Stop at a boundary; left only via clear
import cpu_pkg::*;

module control_sequencer #(
    parameter int OPW    = OPCODE_W,
    parameter int ALUOPW = ALU_W
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic [31:0]       IR_data,
    input  logic              CON_FF,
    input  logic              Stop,
    output logic              Run,
    output logic              PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout,
    output logic              MARin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin,
    output logic              Zin_low, Zin_high,
    output logic              IncPC, Read, Write,
    output logic              Gra, Grb, Grc, Rin, Rout, BAout,
    output logic [ALUOPW-1:0] alu_op
);

    state_t           state, next_state, last;
    logic [OPW-1:0]   opcode;
    logic             is_rr, is_imm, is_ldi, is_mem, is_muldiv;
    logic             unused_ir;

    assign opcode    = IR_data[31 -: OPW];
    assign unused_ir = ^IR_data[31-OPW:0];
    assign last      = last_step(opcode);
    assign is_rr     = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
    assign is_imm    = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign is_ldi    = (opcode == OP_LDI);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);

    // State register with synchronous clear.
    always_ff @(posedge Clock) begin
        if (clear) state <= RESET_S;
        else       state <= next_state;
    end

    // Sequencing: step forward until the opcode's last step, then T0 or halt on Stop.
    always_comb begin
        state_t boundary;
        boundary   = Stop ? HALT_S : T0;
        next_state = state;
        case (state)
            RESET_S: next_state = T0;
            T0:      next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = (opcode == OP_HALT) ? HALT_S : ((last == T2) ? boundary : T3);
            T3:      next_state = (last == T3) ? boundary : T4;
            T4:      next_state = (last == T4) ? boundary : T5;
            T5:      next_state = (last == T5) ? boundary : T6;
            T6:      next_state = (last == T6) ? boundary : T7;
            T7:      next_state = boundary;
            HALT_S:  next_state = HALT_S;
            default: next_state = RESET_S;
        endcase
    end

    // Strobe decode from state and opcode.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIout = 1'b0; LOout = 1'b0;
        MDRout = 1'b0; In_Portout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; HIin = 1'b0;
        LOin = 1'b0; CONin = 1'b0; OutPortin = 1'b0; Zin_low = 1'b0; Zin_high = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op = ALU_ADD;
        Run    = (state != RESET_S) && (state != HALT_S);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_rr || is_imm)        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_ldi || is_mem)  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (is_muldiv)         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else begin
                    case (opcode)
                        OP_BRX:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                        OP_IN:   begin In_Portout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            end
            T4: begin
                if (is_rr)                             begin Grc = 1'b1; Rout = 1'b1; Zin_low = 1'b1; alu_op = alu_for(opcode); end
                else if (is_imm || is_ldi || is_mem)   begin Cout = 1'b1; Zin_low = 1'b1; alu_op = alu_for(opcode); end
                else if (is_muldiv)                    begin Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; Zin_high = 1'b1; alu_op = alu_for(opcode); end
                else if (opcode == OP_BRX)             begin PCout = 1'b1; Yin = 1'b1; end
                else if (opcode == OP_JAL)             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            end
            T5: begin
                if (is_rr || is_imm || is_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_mem)               begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (is_muldiv)            begin Zlowout = 1'b1; LOin = 1'b1; end
                else if (opcode == OP_BRX)     begin Cout = 1'b1; Zin_low = 1'b1; end
            end
            T6: begin
                if (opcode == OP_LD)           begin Read = 1'b1; MDRin = 1'b1; end
                else if (opcode == OP_ST)      begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                else if (is_muldiv)            begin Zhighout = 1'b1; HIin = 1'b1; end
                else if (opcode == OP_BRX)     begin Zlowout = 1'b1; PCin = CON_FF; end
            end
            T7: begin
                if (opcode == OP_LD)           begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (opcode == OP_ST)      Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch and execute sequences for
// several opcodes and compares the full strobe vector every cycle.
import cpu_pkg::*;

module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR_data = 32'h0;
    logic        CON_FF = 1'b0;
    logic        Stop = 1'b0;
    logic        Run;
    logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, OutPortin, Zin_low, Zin_high;
    logic        IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [27:0] PCOUT    = 28'd1 << 0;
    localparam logic [27:0] ZLOWOUT  = 28'd1 << 1;
    localparam logic [27:0] ZHIGHOUT = 28'd1 << 2;
    localparam logic [27:0] HIOUT    = 28'd1 << 3;
    localparam logic [27:0] LOOUT    = 28'd1 << 4;
    localparam logic [27:0] MDROUT   = 28'd1 << 5;
    localparam logic [27:0] INPOUT   = 28'd1 << 6;
    localparam logic [27:0] COUT     = 28'd1 << 7;
    localparam logic [27:0] MARIN    = 28'd1 << 8;
    localparam logic [27:0] PCIN     = 28'd1 << 9;
    localparam logic [27:0] MDRIN    = 28'd1 << 10;
    localparam logic [27:0] IRIN     = 28'd1 << 11;
    localparam logic [27:0] YIN      = 28'd1 << 12;
    localparam logic [27:0] HIIN     = 28'd1 << 13;
    localparam logic [27:0] LOIN     = 28'd1 << 14;
    localparam logic [27:0] CONIN    = 28'd1 << 15;
    localparam logic [27:0] OUTPIN   = 28'd1 << 16;
    localparam logic [27:0] ZINL     = 28'd1 << 17;
    localparam logic [27:0] ZINH     = 28'd1 << 18;
    localparam logic [27:0] INCPC    = 28'd1 << 19;
    localparam logic [27:0] READ     = 28'd1 << 20;
    localparam logic [27:0] WRITE    = 28'd1 << 21;
    localparam logic [27:0] GRA      = 28'd1 << 22;
    localparam logic [27:0] GRB      = 28'd1 << 23;
    localparam logic [27:0] GRC      = 28'd1 << 24;
    localparam logic [27:0] RIN      = 28'd1 << 25;
    localparam logic [27:0] ROUT     = 28'd1 << 26;
    localparam logic [27:0] BAOUT    = 28'd1 << 27;

    localparam logic [27:0] F0 = PCOUT | MARIN | INCPC | ZINL;
    localparam logic [27:0] F1 = ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [27:0] F2 = MDROUT | IRIN;

    logic [27:0] strobes;
    logic [9:0]  bus_src;
    assign strobes = {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, Zin_high, Zin_low,
                      OutPortin, CONin, LOin, HIin, Yin, IRin, MDRin, PCin, MARin,
                      Cout, In_Portout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout};
    assign bus_src = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout, BAout};

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR_data(IR_data), .CON_FF(CON_FF), .Stop(Stop),
        .Run(Run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
        .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin), .Zin_low(Zin_low), .Zin_high(Zin_high),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op)
    );

    always #5 Clock = ~Clock;

    // At most one bus driver in any cycle.
    always @(negedge Clock) begin
        n_checks++;
        if ($countones(bus_src) > 1) begin
            n_fail++;
            $display("FAIL bus_single_source at %0t: sources %b, required at most one set", $time, bus_src);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge Clock);
            n_checks++;
            if (strobes !== 28'h0 || Run !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: strobes %h run %b, required 0000000 run 0", strobes, Run);
            end
        end
        clear = 1'b0;
        @(negedge Clock);
        n_checks++;
        if (strobes !== F0 || Run !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_to_t0: strobes %h run %b, required %h run 1", strobes, Run, F0);
        end
    endtask

    task automatic test_add();
        logic [27:0] exp [0:6];
        exp = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZINL, ZLOWOUT | GRA | RIN, F0};
        IR_data = {OP_ADD, 27'h0};
        #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i] || Run !== 1'b1) begin
                n_fail++;
                $display("FAIL add_step%0d: strobes %h run %b, required %h run 1", i, strobes, Run, exp[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (alu_op !== ALU_ADD) begin
                    n_fail++;
                    $display("FAIL add_alu_op: got %b, required %b", alu_op, ALU_ADD);
                end
            end
        end
    endtask

    task automatic test_andi();
        logic [27:0] exp [0:6];
        exp = '{F0, F1, F2, GRB | ROUT | YIN, COUT | ZINL, ZLOWOUT | GRA | RIN, F0};
        IR_data = {OP_ANDI, 27'h5a5};
        #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i]) begin
                n_fail++;
                $display("FAIL andi_step%0d: strobes %h, required %h", i, strobes, exp[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (alu_op !== ALU_AND) begin
                    n_fail++;
                    $display("FAIL andi_alu_op: got %b, required %b", alu_op, ALU_AND);
                end
            end
        end
    endtask

    task automatic test_ld();
        logic [27:0] exp [0:8];
        exp = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZINL, ZLOWOUT | MARIN,
                READ | MDRIN, MDROUT | GRA | RIN, F0};
        IR_data = {OP_LD, 27'h0};
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i]) begin
                n_fail++;
                $display("FAIL ld_step%0d: strobes %h, required %h", i, strobes, exp[i]);
            end
        end
    endtask

    task automatic test_st();
        logic [27:0] exp [0:8];
        exp = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZINL, ZLOWOUT | MARIN,
                GRA | ROUT | MDRIN, WRITE, F0};
        IR_data = {OP_ST, 27'h0};
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i]) begin
                n_fail++;
                $display("FAIL st_step%0d: strobes %h, required %h", i, strobes, exp[i]);
            end
        end
    endtask

    task automatic test_brx(input logic con);
        logic [27:0] exp [0:7];
        exp = '{F0, F1, F2, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZINL,
                ZLOWOUT | (con ? PCIN : 28'h0), F0};
        IR_data = {OP_BRX, 27'h0};
        CON_FF  = con;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i]) begin
                n_fail++;
                $display("FAIL brx_con%0d_step%0d: strobes %h, required %h", con, i, strobes, exp[i]);
            end
        end
        CON_FF = 1'b0;
    endtask

    task automatic test_mul_clear();
        logic [27:0] exp [0:3];
        logic        seen;
        exp  = '{F0, F1, F2, GRA | ROUT | YIN};
        seen = 1'b0;
        IR_data = {OP_MUL, 27'h0};
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge Clock);
            seen |= Zin_high | LOin | HIin;
            n_checks++;
            if (strobes !== exp[i]) begin
                n_fail++;
                $display("FAIL mul_step%0d: strobes %h, required %h", i, strobes, exp[i]);
            end
        end
        clear = 1'b1;
        @(negedge Clock);
        seen |= Zin_high | LOin | HIin;
        n_checks++;
        if (strobes !== 28'h0 || Run !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_clear_reset: strobes %h run %b, required 0000000 run 0", strobes, Run);
        end
        clear = 1'b0;
        @(negedge Clock);
        seen |= Zin_high | LOin | HIin;
        n_checks++;
        if (strobes !== F0) begin
            n_fail++;
            $display("FAIL mul_clear_restart: strobes %h, required %h", strobes, F0);
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_clear_no_late_loads: seen %b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] exp [0:12];
        exp = '{F0, F1, F2, F0, F1, F2, HIOUT | GRA | RIN, F0, F1, F2,
                PCOUT | GRB | RIN, GRA | ROUT | PCIN, F0};
        IR_data = {5'b11111, 27'h0};
        #1;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i] || Run !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_step%0d: strobes %h run %b, required %h run 1", i, strobes, Run, exp[i]);
            end
            if (i == 3) IR_data = {OP_MFHI, 27'h0};
            if (i == 7) IR_data = {OP_JAL, 27'h0};
        end
    endtask

    task automatic test_halt();
        logic [27:0] exp [0:2];
        exp = '{F0, F1, F2};
        IR_data = {OP_HALT, 27'h0};
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i] || Run !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_fetch%0d: strobes %h run %b, required %h run 1", i, strobes, Run, exp[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            n_checks++;
            if (strobes !== 28'h0 || Run !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold%0d: strobes %h run %b, required 0000000 run 0", i, strobes, Run);
            end
        end
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        n_checks++;
        if (strobes !== F0 || Run !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_recover: strobes %h run %b, required %h run 1", strobes, Run, F0);
        end
    endtask

    task automatic test_stop();
        logic [27:0] exp [0:6];
        exp = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZINL, ZLOWOUT | GRA | RIN, 28'h0};
        IR_data = {OP_SUB, 27'h0};
        #1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge Clock);
            n_checks++;
            if (strobes !== exp[i] || Run !== (i < 6)) begin
                n_fail++;
                $display("FAIL stop_step%0d: strobes %h run %b, required %h run %b",
                         i, strobes, Run, exp[i], (i < 6));
            end
            if (i == 4) begin
                n_checks++;
                if (alu_op !== ALU_SUB) begin
                    n_fail++;
                    $display("FAIL stop_sub_alu_op: got %b, required %b", alu_op, ALU_SUB);
                end
            end
            Stop = (i == 3) || (i == 5);
        end
        Stop  = 1'b0;
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        @(negedge Clock);
        n_checks++;
        if (strobes !== F0) begin
            n_fail++;
            $display("FAIL stop_recover: strobes %h, required %h", strobes, F0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_andi();
        test_ld();
        test_st();
        test_brx(1'b0);
        test_brx(1'b1);
        test_back_to_back();
        test_mul_clear();
        test_stop();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
